reg_write_demux: RTL



---
 rtl/reg_write_pkg.sv | 14 +
 rtl/reg_write_demux_decoder.sv | 20 ++
 rtl/reg_write_demux.sv | 89 ++++++++
 3 files changed

// File: rtl/reg_write_pkg.sv
// Shared constants and the staging-record type for the register-bank write path.
package reg_write_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 2 ** ADDR_W;

   typedef struct packed {
      logic              full;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

endpackage

// File: rtl/reg_write_demux_decoder.sv
// Address-to-one-hot write-enable decoder; bit 0 is tied low so register 0 is never written.
module decoder_5to32
   import reg_write_pkg::*;
(
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [NREGS-1:0]  onehot
);

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
         if (gi == 0) begin : g_zero
            assign onehot[gi] = 1'b0;
         end else begin : g_bit
            assign onehot[gi] = en && (addr == ADDR_W'(gi));
         end
      end
   endgenerate

endmodule

// File: rtl/reg_write_demux.sv
// Write side of the 32-entry register bank: one-entry staging register, one-hot commit, flat read bus.
// Optional macro REG_WRITE_BYPASS_EN: a staged value is visible on q_flat one cycle before it commits.
module reg_write_demux
   import reg_write_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    freeze,
   output logic [NREGS*DATA_W-1:0] q_flat,
   output logic                    commit_valid,
   output logic [ADDR_W-1:0]       commit_addr
);

   stage_t             stg_q, stg_d;
   logic               commit_valid_q, commit_valid_d;
   logic [ADDR_W-1:0]  commit_addr_q, commit_addr_d;
   logic [DATA_W-1:0]  regs_q [NREGS];
   logic [DATA_W-1:0]  regs_d [NREGS];
   logic [NREGS-1:0]   wr_en;
   logic               accept;
   logic               commit;

   assign wr_ready = !reset && (!stg_q.full || !freeze);
   assign accept   = wr_valid && wr_ready;
   assign commit   = stg_q.full && !freeze;

   decoder_5to32 u_dec (
      .en     (commit),
      .addr   (stg_q.addr),
      .onehot (wr_en)
   );

   // A same-edge accept overrides the drain, keeping one write per cycle.
   always_comb begin
      stg_d = stg_q;
      if (commit) begin
         stg_d.full = 1'b0;
      end
      if (accept) begin
         stg_d = '{full: 1'b1, addr: wr_addr, data: wr_data};
      end
      commit_valid_d = commit;
      commit_addr_d  = commit ? stg_q.addr : commit_addr_q;
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = wr_en[i] ? stg_q.data : regs_q[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stg_q          <= '0;
         commit_valid_q <= 1'b0;
         commit_addr_q  <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         stg_q          <= stg_d;
         commit_valid_q <= commit_valid_d;
         commit_addr_q  <= commit_addr_d;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign commit_valid = commit_valid_q;
   assign commit_addr  = commit_addr_q;

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_q
         if (gi == 0) begin : g_zero
            assign q_flat[gi*DATA_W +: DATA_W] = '0;
         end else begin : g_reg
`ifdef REG_WRITE_BYPASS_EN
            assign q_flat[gi*DATA_W +: DATA_W] =
               (stg_q.full && (stg_q.addr == ADDR_W'(gi))) ? stg_q.data : regs_q[gi];
`else
            assign q_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
`endif
         end
      end
   endgenerate

endmodule
